// File: rtl/capture_sched_pkg.sv
// Shared types and constants for the capture scheduler: one-hot state encoding
// and the length of the capture-engine clear pulse.
package capture_sched_pkg;

    localparam int CLEAR_CYCLES = 2;
    localparam int CLR_W        = 2;

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_CLEAR     = 6'b000010,
        S_START     = 6'b000100,
        S_WAIT_DONE = 6'b001000,
        S_READ      = 6'b010000,
        S_HOLDOFF   = 6'b100000
    } sched_state_e;

endpackage

// File: rtl/capture_read_pipe.sv
// Sample RAM readout: address counter, single-entry output register and
// valid/ready handshake, streaming DEPTH samples per go pulse.
module capture_read_pipe #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              go_i,
    input  logic              flush_i,
    input  logic [CNT_W-1:0]  idx_i,
    output logic              done_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic [CNT_W-1:0]  out_idx_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              active_q, active_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              accept;
    logic              load;
    logic              at_last;

    // The RAM is always addressed with next-cycle's addr_q, so rd_data always
    // belongs to addr_q and a held address keeps its data valid during stalls.
    always_comb begin
        active_d = active_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        last_d   = last_q;
        idx_d    = idx_q;
        accept   = valid_q && out_ready_i;
        at_last  = (addr_q == LAST_ADDR);
        load     = active_q && (!valid_q || out_ready_i);
        if (flush_i) begin
            active_d = 1'b0;
            addr_d   = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else if (go_i) begin
            active_d = 1'b1;
            addr_d   = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = rd_data_i;
            last_d  = at_last;
            idx_d   = idx_i;
            if (at_last) begin
                active_d = 1'b0;
                addr_d   = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            active_q <= active_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
        end
    end

    assign rd_addr_o   = addr_d;
    assign done_o      = accept && last_q && !flush_i;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;
    assign out_idx_o   = idx_q;

endmodule

// File: rtl/capture_scheduler.sv
// Burst sequencer for the sample-capture datapath: clear/start engine, wait for
// RAM-full, stream samples out, hold off, repeat. CAPTURE_TIMEOUT_EN adds a WAIT_DONE watchdog.
module capture_scheduler
    import capture_sched_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8,
    parameter int HOLD_W = 16
`ifdef CAPTURE_TIMEOUT_EN
    , parameter int TMO_W = 24
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_arm,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [HOLD_W-1:0] cmd_holdoff,
    input  logic              cmd_abort,
    output logic              busy,
    output logic              cap_reset_n,
    output logic              cap_start,
    input  logic              cap_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  out_idx
`ifdef CAPTURE_TIMEOUT_EN
    , output logic            err_timeout
`endif
);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [HOLD_W-1:0] holdoff_q, holdoff_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CLR_W-1:0]  clr_q, clr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W:0]   hold_inc;
    logic              go;
    logic              flush;
    logic              rd_done;
`ifdef CAPTURE_TIMEOUT_EN
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
`endif

    assign flush = cmd_abort && (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        holdoff_d = holdoff_q;
        idx_d     = idx_q;
        clr_d     = clr_q;
        hold_d    = hold_q;
        go        = 1'b0;
        hold_inc  = {1'b0, hold_q} + 1'b1;
`ifdef CAPTURE_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_arm) begin
                    count_d   = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                    holdoff_d = cmd_holdoff;
                    idx_d     = '0;
                    clr_d     = '0;
                    state_d   = S_CLEAR;
`ifdef CAPTURE_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == CLR_W'(CLEAR_CYCLES - 1)) state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT_DONE;
`ifdef CAPTURE_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT_DONE: begin
                if (cap_done) begin
                    go      = 1'b1;
                    state_d = S_READ;
                end
`ifdef CAPTURE_TIMEOUT_EN
                else begin
                    tmo_d = tmo_q + 1'b1;
                    if (&tmo_d) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
`endif
            end
            S_READ: begin
                if (rd_done) begin
                    if (idx_q + 1'b1 == count_q) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        hold_d  = '0;
                        state_d = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                // A zero holdoff still spends one cycle here.
                hold_d = hold_inc[HOLD_W-1:0];
                if (hold_inc >= {1'b0, holdoff_q}) begin
                    clr_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            go      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            holdoff_q <= '0;
            idx_q     <= '0;
            clr_q     <= '0;
            hold_q    <= '0;
`ifdef CAPTURE_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            holdoff_q <= holdoff_d;
            idx_q     <= idx_d;
            clr_q     <= clr_d;
            hold_q    <= hold_d;
`ifdef CAPTURE_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    // The engine is only cleared in IDLE/CLEAR so RAM contents survive readout.
    assign busy        = (state_q != S_IDLE);
    assign cap_reset_n = !((state_q == S_IDLE) || (state_q == S_CLEAR));
    assign cap_start   = (state_q == S_START) || (state_q == S_WAIT_DONE);
`ifdef CAPTURE_TIMEOUT_EN
    assign err_timeout = err_q;
`endif

    capture_read_pipe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_read_pipe (
        .clk         (clk),
        .rst_ni      (reset),
        .go_i        (go),
        .flush_i     (flush),
        .idx_i       (idx_q),
        .done_o      (rd_done),
        .rd_addr_o   (rd_addr),
        .rd_data_i   (rd_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .out_idx_o   (out_idx)
    );

endmodule
